// File: rtl/dmem_arb_pkg.sv
// Shared types, constants and the address legality rule for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int MAX_NREQ = 4;
  localparam int IDX_W    = $clog2(MAX_NREQ);
  localparam int DATA_W   = 32;

  // A word access is legal when it is 4-byte aligned and all four bytes
  // fall inside the memory. The compare is done in full 32 bits because
  // the memory itself wraps its index and would silently alias.
  function automatic logic addr_legal(input logic [31:0] addr, input logic [31:0] depth);
    return (addr[1:0] == 2'b00) && (addr < (depth - 32'd3));
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Combinational round-robin picker: first masked request at or above the
// pointer, wrapping at NREQ. Produces a one-hot grant and its index.
module rr_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  input  logic [NREQ-1:0]  i_mask,
  output logic [NREQ-1:0]  o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  int w_best;
  int w_sel;
  int w_dist;

  // Pick the eligible requester with the smallest circular distance from the pointer.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_best  = NREQ;
    w_sel   = 0;
    w_dist  = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (i_req[i] && i_mask[i]) begin
        w_dist = (i >= int'(i_ptr)) ? (i - int'(i_ptr)) : (i + NREQ - int'(i_ptr));
        if (w_dist < w_best) begin
          w_best = w_dist;
          w_sel  = i;
        end
      end
    end
    if (w_best < NREQ) begin
      o_any = 1'b1;
      o_idx = IDX_W'(w_sel);
      for (int i = 0; i < NREQ; i++) begin
        o_grant[i] = (i == w_sel);
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port byte-addressed data memory between NREQ word
// requesters with round-robin arbitration, locked sequences and rejection
// of misaligned / out-of-range words. Responses arrive one cycle after accept.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      i_req_valid,
  output logic [NREQ-1:0]      o_req_ready,
  input  logic [NREQ-1:0]      i_req_we,
  input  logic [NREQ-1:0]      i_req_lock,
  input  logic [NREQ*32-1:0]   i_req_addr,
  input  logic [NREQ*32-1:0]   i_req_wdata,
  output logic [NREQ-1:0]      o_rsp_valid,
  output logic                 o_rsp_err,
  output logic [31:0]          o_rsp_rdata,
  output logic [31:0]          o_mem_address,
  output logic                 o_mem_write_en,
  output logic [31:0]          o_mem_data_in,
  input  logic [31:0]          i_mem_data_out
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] w_ptr_nxt;

  logic [NREQ-1:0]  w_mask;
  logic [NREQ-1:0]  w_grant;
  logic [IDX_W-1:0] w_idx;
  logic             w_any;
  logic             w_accept;
  logic             w_legal;
  logic             w_issue;

  logic [31:0]      w_addr;
  logic [31:0]      w_wdata;
  logic             w_we;
  logic             w_lock;

  logic [31:0]      r_mem_addr;
  logic [31:0]      r_mem_wdata;

  logic [NREQ-1:0]  r_rsp_vld_p1;
  logic             r_rsp_err_p1;
  logic [31:0]      r_rsp_rdata_p1;

  // While locked only the owner is eligible; otherwise everyone is.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_mask[i] = (r_state == ARB) || (IDX_W'(i) == r_owner);
    end
  end

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .i_req   (i_req_valid),
    .i_ptr   (r_ptr),
    .i_mask  (w_mask),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Route the granted requester's fields onto the shared datapath.
  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    w_we    = 1'b0;
    w_lock  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDX_W'(i) == w_idx) begin
        w_addr  = i_req_addr[i*32 +: 32];
        w_wdata = i_req_wdata[i*32 +: 32];
        w_we    = i_req_we[i];
        w_lock  = i_req_lock[i];
      end
    end
  end

  // Reset suppresses every grant, so a write presented during rst never reaches memory.
  assign o_req_ready = rst ? '0 : w_grant;
  assign w_accept    = w_any && !rst;
  assign w_legal     = addr_legal(w_addr, 32'(DEPTH));
  assign w_issue     = w_accept && w_legal;
  assign w_ptr_nxt   = (int'(w_idx) == NREQ - 1) ? '0 : (w_idx + IDX_W'(1));

  // Memory pins: live value on a legal accept, otherwise the last issued value.
  assign o_mem_write_en = w_issue && w_we;
  assign o_mem_address  = w_issue ? w_addr  : r_mem_addr;
  assign o_mem_data_in  = w_issue ? w_wdata : r_mem_wdata;

  // Lock state transitions; an illegal access still takes or releases the lock.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB:     if (w_accept && w_lock)  w_state_nxt = LOCKED;
      LOCKED:  if (w_accept && !w_lock) w_state_nxt = ARB;
      default: w_state_nxt = ARB;
    endcase
  end

  // FSM state, round-robin pointer and lock owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB;
      r_ptr   <= '0;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) r_ptr <= w_ptr_nxt;
      if ((r_state == ARB) && w_accept && w_lock) r_owner <= w_idx;
    end
  end

  // Hold the last issued address / write data so the pins stay quiet when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_issue) begin
      r_mem_addr  <= w_addr;
      r_mem_wdata <= w_wdata;
    end
  end

  // ---- stage p1: response registered one cycle after accept ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_vld_p1   <= '0;
      r_rsp_err_p1   <= 1'b0;
      r_rsp_rdata_p1 <= '0;
    end else begin
      r_rsp_vld_p1   <= w_accept ? w_grant : '0;
      r_rsp_err_p1   <= w_accept && !w_legal;
      r_rsp_rdata_p1 <= (w_issue && !w_we) ? i_mem_data_out : '0;
    end
  end

  assign o_rsp_valid = r_rsp_vld_p1;
  assign o_rsp_err   = r_rsp_err_p1;
  assign o_rsp_rdata = r_rsp_rdata_p1;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port, byte-addressed data memory between NREQ word-access requesters (port 0 = CPU load/store unit, port 1 = debug/loader DMA). Round-robin arbitration grants at most one transaction per cycle, supports locked read-modify-write sequences, and rejects misaligned or out-of-range words before they reach memory. Sits between the requesters and the memory's address/write_en/data_in/data_out pins.

## Interface
- NREQ, 2: number of requesters (2..4).
- DEPTH, 256: memory depth in bytes; word addresses valid up to DEPTH-4.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  [NREQ]  requester i presents a transaction.
- req_ready  out  [NREQ]  grant; transaction i accepted when valid & ready.
- req_we  in  [NREQ]  1 = write, 0 = read.
- req_lock  in  [NREQ]  hold grant after this transaction.
- req_addr  in  [NREQ][32]  byte address.
- req_wdata  in  [NREQ][32]  write data.
- rsp_valid  out  [NREQ]  one-cycle response pulse to requester i.
- rsp_err  out  1  qualifies rsp_valid; 1 = rejected access.
- rsp_rdata  out  32  read data (0 for writes and errors).
- mem_address  out  32  to memory address.
- mem_write_en  out  1  to memory write enable.
- mem_data_in  out  32  to memory write data.
- mem_data_out  in  32  memory combinational read data.

## Operation
- States: ARB, LOCKED. Reset -> ARB, rr pointer = 0, lock owner = 0.
- ARB: grant the first requester with req_valid, searching from the rr pointer upward, wrapping at NREQ. At most one req_ready high. No valid -> no grant.
- On accept by requester g: rr pointer <= (g+1) mod NREQ. If req_lock[g] = 1, go to LOCKED with owner = g.
- LOCKED: only the owner may be granted; other requesters stall with ready = 0. Owner's accepted transaction with req_lock = 0 -> ARB. Pointer still advances past the owner.
- Legality check on the granted request: legal iff addr[1:0] == 0 and addr < DEPTH-3, compared in full 32 bits. Memory indexing wraps, so the arbiter must block out-of-range words.
- Legal accepted transaction: mem_address = req_addr[g]. mem_write_en = req_we[g] in the same cycle (combinational), so memory writes at the next edge. mem_data_in = req_wdata[g].
- Illegal accepted transaction: mem_write_en = 0. The response carries rsp_err = 1.
- Idle or no accept: mem_write_en = 0; mem_address and mem_data_in hold their last value (no toggling requirement).
- Response: registered, one cycle after accept. rsp_valid[g] = 1 for exactly one cycle. Read: rsp_rdata = mem_data_out sampled at the accept edge. Write: rsp_rdata = 0. Error: rsp_rdata = 0.
- Lock on an illegal transaction is still honoured (state change happens); lock release likewise.

## Timing
- Reset values: req_ready = 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, mem_write_en = 0, mem_address = 0, mem_data_in = 0.
- req_ready is combinational from req_valid, state and pointer. No combinational path from mem_data_out to any output.
- Throughput: one transaction per cycle; back-to-back accepts from the same or different requesters allowed.
- Latency: accept at edge N, rsp_valid high during cycle N+1.
- Read-after-write by any port in consecutive cycles returns the new data, because the write commits at the accept edge.
- rst asserted mid-transaction: a pending response is dropped (rsp_valid = 0 next cycle); a write accepted in the same cycle as rst is not issued (mem_write_en forced 0 while rst = 1); lock is cleared.
- A requester must hold its request fields stable while valid & !ready.

## Structure
- Package dmem_arb_pkg:
  - state enum (ARB, LOCKED);
  - MAX_NREQ = 4;
  - function addr_legal(addr, depth).
- Sub-module rr_arbiter: pure combinational; inputs request vector, pointer, and mask (LOCKED -> owner-only); outputs one-hot grant and index.
- Top holds the FSM, pointer/owner registers, mux, and response register.

## Test plan
- Reset with all requesters valid -> all outputs 0 during rst; first cycle after release port 0 is granted (pointer 0).
- Port 1 writes 0xDEADBEEF at 0x10, then port 0 reads 0x10 next cycle -> mem_write_en pulse at first accept; read rsp_rdata = 0xDEADBEEF, rsp_valid[0] one cycle after accept.
- Both ports valid continuously, 6 cycles -> grants alternate 0,1,0,1,0,1; each rsp_valid follows its grant by 1 cycle.
- Port 1 accepts with lock = 1, then two more with lock = 0 on the last one, while port 0 stays valid -> port 0 stalls 3 cycles, then is granted.
- Read at 0x11 and at 0xFE (DEPTH = 256) -> no memory write, rsp_err = 1, rsp_rdata = 0; read at 0xFC is legal.
- rst pulsed in the same cycle as a write accept to 0x20 -> memory byte 0x20 unchanged, no rsp_valid, state ARB afterward.
